mem_stage_ctrl: RTL and testbench

- Memory stage of the 5-stage WISC pipeline; the consumer end of the execute-stage output interface.
- Takes the registered EX/MEM fields and drives the data memory through a level request/done handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Selects the writeback value and registers the MEM/WB fields for the writeback stage.

---
 rtl/mem_stage_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage of the 5-stage WISC pipeline.
// Drives the data memory via a level req/done handshake, stalls the upstream
// pipeline while an access is outstanding, selects the writeback value and
// registers the MEM/WB fields. Errors and halt are sticky until reset.
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [DATA_W-1:0] reg2Data,
    input  logic [DATA_W-1:0] setVal,
    input  logic [DATA_W-1:0] nextPc,
    input  logic [DATA_W-1:0] instr,
    input  logic              memEn,
    input  logic              memWrt,
    input  logic              regWrt,
    input  logic [2:0]        writeReg,
    input  logic [2:0]        regWrtSrc,
    input  logic              halt,
    input  logic              errIn,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] wbData,
    output logic              wbRegWrt,
    output logic [2:0]        wbReg,
    output logic [DATA_W-1:0] instrOut,
    output logic              haltOut,
    output logic              err
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(16'h0800);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ERR    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic              wbRegWrt_q, wbRegWrt_d;
    logic [2:0]        wbReg_q, wbReg_d;
    logic [DATA_W-1:0] instrOut_q, instrOut_d;
    logic              haltOut_q, haltOut_d;
    logic              err_q, err_d;

    logic              active;
    logic              capture;
    logic              timeout;
    logic              bad_sel;
    logic              misalign;
    logic [DATA_W-1:0] wb_sel;

    // Writeback source mux; codes 5-7 are illegal and yield zero.
    function automatic logic [DATA_W-1:0] sel_wb(
        input logic [2:0]        src,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] setv,
        input logic [DATA_W-1:0] pc2,
        input logic [DATA_W-1:0] r2
    );
        case (src)
            3'd0:    return alu;
            3'd1:    return rdata;
            3'd2:    return setv;
            3'd3:    return pc2;
            3'd4:    return r2;
            default: return '0;
        endcase
    endfunction

    // Memory handshake, stall and capture qualification.
    always_comb begin
        active    = (state_q == S_IDLE) || (state_q == S_WAIT);
        // Request is squashed combinationally while reset is held.
        mem_req   = rst & memEn & active;
        mem_wr    = memWrt & mem_req;
        // Misaligned accesses still go out, word-aligned.
        mem_addr  = {aluOut[DATA_W-1:1], 1'b0};
        mem_wdata = reg2Data;
        stall     = (mem_req & ~mem_done) | ~active;
        capture   = ~stall & active;
        misalign  = memEn & aluOut[0];
        bad_sel   = (regWrtSrc > 3'd4);
        wb_sel    = sel_wb(regWrtSrc, aluOut, mem_rdata, setVal, nextPc, reg2Data);
    end

    // Next-state logic: the counter reaches TIMEOUT on the cycle ERR is entered,
    // i.e. after TIMEOUT cycles spent in WAIT without mem_done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (capture && halt) begin
                    state_d = S_HALTED;
                end else if (mem_req && !mem_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    cnt_d   = '0;
                    state_d = halt ? S_HALTED : S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + 1'b1;
                    timeout = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR:    state_d = S_ERR;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // MEM/WB next values: capture when unstalled, hold otherwise.
    always_comb begin
        wbData_d   = wbData_q;
        wbRegWrt_d = wbRegWrt_q;
        wbReg_d    = wbReg_q;
        instrOut_d = instrOut_q;
        haltOut_d  = haltOut_q;
        err_d      = err_q;
        if (capture) begin
            wbData_d   = wb_sel;
            wbRegWrt_d = regWrt & ~(memEn & memWrt);
            wbReg_d    = writeReg;
            instrOut_d = instr;
            haltOut_d  = haltOut_q | halt;
            err_d      = err_q | errIn | bad_sel | misalign;
        end
        if (timeout) begin
            wbRegWrt_d = 1'b0;
            err_d      = 1'b1;
        end
    end

    // State, counter and MEM/WB registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wbData_q   <= '0;
            wbRegWrt_q <= 1'b0;
            wbReg_q    <= '0;
            instrOut_q <= NOP_INSTR;
            haltOut_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wbData_q   <= wbData_d;
            wbRegWrt_q <= wbRegWrt_d;
            wbReg_q    <= wbReg_d;
            instrOut_q <= instrOut_d;
            haltOut_q  <= haltOut_d;
            err_q      <= err_d;
        end
    end

    assign wbData   = wbData_q;
    assign wbRegWrt = wbRegWrt_q;
    assign wbReg    = wbReg_q;
    assign instrOut = instrOut_q;
    assign haltOut  = haltOut_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a vector table for single-cycle
// transactions plus hand-written sequences for wait, timeout, halt and reset.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] aluOut, reg2Data, setVal, nextPc, instr;
    logic        memEn, memWrt, regWrt, halt, errIn;
    logic [2:0]  writeReg, regWrtSrc;
    logic        mem_req, mem_wr, mem_done, stall;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] wbData, instrOut;
    logic        wbRegWrt, haltOut, err;
    logic [2:0]  wbReg;

    int total = 0;
    int bad   = 0;

    mem_stage_ctrl #(.DATA_W(16), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .aluOut(aluOut), .reg2Data(reg2Data), .setVal(setVal), .nextPc(nextPc),
        .instr(instr), .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt),
        .writeReg(writeReg), .regWrtSrc(regWrtSrc), .halt(halt), .errIn(errIn),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stall(stall), .wbData(wbData), .wbRegWrt(wbRegWrt), .wbReg(wbReg),
        .instrOut(instrOut), .haltOut(haltOut), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu;
        logic [2:0]  src;
        logic        men;
        logic        mwr;
        logic        rwr;
        logic [2:0]  wreg;
        logic        done;
        logic [15:0] rdata;
        logic        e_req;
        logic        e_stall;
        logic [15:0] e_addr;
        logic [15:0] e_wb;
        logic        e_we;
        logic [2:0]  e_reg;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aluOut = 16'h0; memEn = 1'b0; memWrt = 1'b0; regWrt = 1'b0;
        writeReg = 3'd0; regWrtSrc = 3'd0; halt = 1'b0; errIn = 1'b0;
        mem_done = 1'b0; mem_rdata = 16'h0; instr = 16'h0800;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        int waited;
        rst = 1'b0;
        reg2Data = 16'h00AA; setVal = 16'h0001; nextPc = 16'h0102;
        idle_inputs();

        vecs[0] = '{16'h1234, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b1, 3'd3};
        vecs[1] = '{16'h0040, 3'd1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 1'b1, 3'd5};
        vecs[2] = '{16'h7777, 3'd2, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h7776, 16'h0001, 1'b1, 3'd1};
        vecs[3] = '{16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0102, 1'b1, 3'd7};
        vecs[4] = '{16'h0022, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0022, 16'h00AA, 1'b0, 3'd2};
        vecs[5] = '{16'h0100, 3'd4, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0100, 16'h00AA, 1'b0, 3'd4};

        // Reset state, with a request attempted while reset is held
        memEn = 1'b1;
        tick(); tick();
        check("rst_mem_req", 16'(mem_req), 16'h0);
        check("rst_wbData", wbData, 16'h0000);
        check("rst_instrOut", instrOut, 16'h0800);
        check("rst_flags", {13'h0, wbRegWrt, haltOut, err}, 16'h0);
        idle_inputs();
        rst = 1'b1;
        tick();

        // Table of single-cycle transactions
        for (int i = 0; i < 6; i++) begin
            aluOut = vecs[i].alu; regWrtSrc = vecs[i].src; memEn = vecs[i].men;
            memWrt = vecs[i].mwr; regWrt = vecs[i].rwr; writeReg = vecs[i].wreg;
            mem_done = vecs[i].done; mem_rdata = vecs[i].rdata; instr = 16'h1000 + 16'(i);
            #1;
            check($sformatf("v%0d_mem_req", i), 16'(mem_req), 16'(vecs[i].e_req));
            check($sformatf("v%0d_stall", i), 16'(stall), 16'(vecs[i].e_stall));
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            tick();
            idle_inputs();
            check($sformatf("v%0d_wbData", i), wbData, vecs[i].e_wb);
            check($sformatf("v%0d_wbRegWrt", i), 16'(wbRegWrt), 16'(vecs[i].e_we));
            check($sformatf("v%0d_wbReg", i), 16'(wbReg), 16'(vecs[i].e_reg));
            check($sformatf("v%0d_instrOut", i), instrOut, 16'h1000 + 16'(i));
        end
        check("table_err", 16'(err), 16'h0);

        // ALU op sets wbRegWrt=1, then a store with three wait cycles
        aluOut = 16'h5555; regWrt = 1'b1; writeReg = 3'd6;
        tick();
        check("pre_store_we", 16'(wbRegWrt), 16'h1);
        aluOut = 16'h0010; memEn = 1'b1; memWrt = 1'b1; regWrt = 1'b1; regWrtSrc = 3'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("st_stall_c%0d", c), 16'(stall), 16'h1);
            check($sformatf("st_req_wr_c%0d", c), {14'h0, mem_req, mem_wr}, 16'h3);
            check($sformatf("st_wdata_c%0d", c), mem_wdata, 16'h00AA);
            check($sformatf("st_hold_we_c%0d", c), 16'(wbRegWrt), 16'h1);
            tick();
        end
        mem_done = 1'b1;
        #1;
        check("st_done_stall", 16'(stall), 16'h0);
        tick();
        idle_inputs();
        check("st_wbRegWrt", 16'(wbRegWrt), 16'h0);
        check("st_err", 16'(err), 16'h0);

        // Misaligned zero-wait load
        aluOut = 16'h0011; memEn = 1'b1; regWrtSrc = 3'd1; regWrt = 1'b1;
        mem_done = 1'b1; mem_rdata = 16'h4321;
        #1;
        check("mis_addr", mem_addr, 16'h0010);
        check("mis_err_before", 16'(err), 16'h0);
        tick();
        idle_inputs();
        check("mis_err", 16'(err), 16'h1);
        tick();
        check("mis_err_sticky", 16'(err), 16'h1);
        do_reset();
        check("mis_err_cleared", 16'(err), 16'h0);

        // Illegal writeback source
        aluOut = 16'h9999; regWrtSrc = 3'd6; regWrt = 1'b1;
        tick();
        idle_inputs();
        check("badsel_wbData", wbData, 16'h0000);
        check("badsel_err", 16'(err), 16'h1);
        do_reset();

        // Timeout: load never completes
        aluOut = 16'h0080; memEn = 1'b1; regWrtSrc = 3'd1; regWrt = 1'b1;
        waited = 0;
        while (err !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("to_cycles", 16'(waited), 16'd32);
        check("to_err", 16'(err), 16'h1);
        check("to_stall", 16'(stall), 16'h1);
        check("to_mem_req", 16'(mem_req), 16'h0);
        check("to_we", 16'(wbRegWrt), 16'h0);
        idle_inputs();
        tick(); tick(); tick();
        check("to_err_sticky", 16'(err), 16'h1);
        check("to_stall_sticky", 16'(stall), 16'h1);
        do_reset();
        check("to_err_reset", 16'(err), 16'h0);

        // Halt
        aluOut = 16'h0ABC; halt = 1'b1; instr = 16'hF000;
        tick();
        idle_inputs();
        check("halt_out", 16'(haltOut), 16'h1);
        check("halt_instr", instrOut, 16'hF000);
        check("halt_wbData", wbData, 16'h0ABC);
        memEn = 1'b1; aluOut = 16'h0200; regWrt = 1'b1;
        #1;
        check("halt_mem_req", 16'(mem_req), 16'h0);
        check("halt_stall", 16'(stall), 16'h1);
        tick();
        check("halt_wb_hold", wbData, 16'h0ABC);
        check("halt_sticky", 16'(haltOut), 16'h1);
        idle_inputs();
        do_reset();

        // Reset asserted mid-WAIT takes effect immediately
        aluOut = 16'h0300; regWrtSrc = 3'd0; regWrt = 1'b1; tick();
        check("pre_mid_wb", wbData, 16'h0300);
        memEn = 1'b1; regWrtSrc = 3'd1; instr = 16'h2222;
        tick(); tick();
        check("mid_wait_stall", 16'(stall), 16'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_req", 16'(mem_req), 16'h0);
        check("mid_rst_wbData", wbData, 16'h0000);
        check("mid_rst_instr", instrOut, 16'h0800);
        check("mid_rst_stall", 16'(stall), 16'h0);
        idle_inputs();
        tick();
        rst = 1'b1;
        aluOut = 16'h4242; regWrt = 1'b1; writeReg = 3'd2;
        #1;
        check("post_rst_stall", 16'(stall), 16'h0);
        tick();
        check("post_rst_wbData", wbData, 16'h4242);
        check("post_rst_wbReg", 16'(wbReg), 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule
